// File: rtl/sha_block_fetch_if.sv
// -----------------------------------------------------------------------------
// sha_block_fetch_if
//
// Groups every signal of sha_block_fetch except clock and reset:
//   fetch control   : fetch_start, fetch_base_addr -> busy, fetch_done, fetch_err
//   BRAM read port  : sha_start_read, sha_bram_addr -> sha_bram_read_data,
//                     bram_complete
//   message stream  : msg_word, msg_idx, msg_valid -> msg_ready
//
// Modports:
//   master : the fetch engine (drives requests, read port and message stream)
//   slave  : its environment (requester, BRAM interface and SHA core)
// -----------------------------------------------------------------------------
interface sha_block_fetch_if;
  logic        fetch_start;
  logic [31:0] fetch_base_addr;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;

  logic        sha_start_read;
  logic [31:0] sha_bram_addr;
  logic [31:0] sha_bram_read_data;
  logic        bram_complete;

  logic [31:0] msg_word;
  logic [3:0]  msg_idx;
  logic        msg_valid;
  logic        msg_ready;

  modport master (
    input  fetch_start, fetch_base_addr, sha_bram_read_data, bram_complete,
           msg_ready,
    output busy, fetch_done, fetch_err, sha_start_read, sha_bram_addr,
           msg_word, msg_idx, msg_valid
  );

  modport slave (
    output fetch_start, fetch_base_addr, sha_bram_read_data, bram_complete,
           msg_ready,
    input  busy, fetch_done, fetch_err, sha_start_read, sha_bram_addr,
           msg_word, msg_idx, msg_valid
  );
endinterface : sha_block_fetch_if

// File: rtl/sha_block_fetch.sv
// -----------------------------------------------------------------------------
// sha_block_fetch
//
// Reads one SHA message block (WORDS x 32-bit) from BRAM, one read at a time,
// and streams the words in order to the SHA compression core over a
// valid/ready handshake. Each BRAM read handshake is fully closed
// (bram_complete seen low again) before the next request is raised.
//
// Parameters:
//   WORDS          words per block, 1..16
//   ADDR_STRIDE    byte increment between consecutive word addresses
//   TIMEOUT_CYCLES watchdog limit (only with SHA_FETCH_TIMEOUT_EN), 1..255
//
// Ports:
//   axi_clk  clock, rising edge
//   axi_rst  asynchronous active-low reset
//   bus      sha_block_fetch_if.master (fetch control, BRAM read port,
//            message stream)
//
// Optional feature macro: SHA_FETCH_TIMEOUT_EN
//   Adds an 8-bit watchdog on the REQ/RELEASE wait states and an ABORT state
//   that raises the sticky fetch_err flag. Without it fetch_err is tied low
//   and the BRAM waits are unbounded.
// -----------------------------------------------------------------------------
module sha_block_fetch #(
  parameter int WORDS          = 16,
  parameter int ADDR_STRIDE    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               axi_clk,
  input logic               axi_rst,
  sha_block_fetch_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RELEASE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
`ifdef SHA_FETCH_TIMEOUT_EN
    ,
    ST_ABORT   = 3'd5
`endif
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(WORDS - 1);
  localparam logic [31:0] STRIDE   = 32'(ADDR_STRIDE);

  state_t     state_q;
  state_t     state_next;
  logic [3:0] count_q;

`ifdef SHA_FETCH_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_q;
  logic       wd_expired;

  // Only the two BRAM wait states are guarded; the count restarts whenever
  // the state changes, so each wait gets the full budget.
  assign wd_expired = ((state_q == ST_REQ) || (state_q == ST_RELEASE)) &&
                      (wd_q == WD_LAST);
`else
  // The watchdog limit has no consumer when the watchdog is not built.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned before the case so every path drives state_next;
    // a missing branch would otherwise infer a latch.
    state_next = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch_start) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (bus.bram_complete) state_next = ST_RELEASE;
`ifdef SHA_FETCH_TIMEOUT_EN
        else if (wd_expired)   state_next = ST_ABORT;
`endif
      end
      ST_RELEASE: begin
        // Low complete means the BRAM interface is back in idle.
        if (!bus.bram_complete) state_next = ST_PRESENT;
`ifdef SHA_FETCH_TIMEOUT_EN
        else if (wd_expired)    state_next = ST_ABORT;
`endif
      end
      ST_PRESENT: begin
        if (bus.msg_ready) state_next = (count_q == LAST_IDX) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
`ifdef SHA_FETCH_TIMEOUT_EN
      ST_ABORT: begin
        if (!bus.bram_complete) state_next = ST_IDLE;
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs
  // ---------------------------------------------------------------------------
  // Status outputs are decoded from state_next and registered, so they change
  // together with the state and are glitch-free.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state_q            <= ST_IDLE;
      count_q            <= '0;
      bus.busy           <= 1'b0;
      bus.fetch_done     <= 1'b0;
      bus.sha_start_read <= 1'b0;
      bus.msg_valid      <= 1'b0;
      bus.sha_bram_addr  <= '0;
      bus.msg_word       <= '0;
      bus.msg_idx        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q            <= state_next;
      bus.busy           <= (state_next != ST_IDLE);
      bus.fetch_done     <= (state_next == ST_DONE);
      bus.sha_start_read <= (state_next == ST_REQ);
      bus.msg_valid      <= (state_next == ST_PRESENT);

      // The address register tracks base + count*stride directly, so no
      // multiplier is needed and wrap past 2^32 falls out naturally.
      if ((state_q == ST_IDLE) && bus.fetch_start) begin
        count_q           <= '0;
        bus.sha_bram_addr <= bus.fetch_base_addr;
      end

      if ((state_q == ST_REQ) && bus.bram_complete) begin
        bus.msg_word <= bus.sha_bram_read_data;
        bus.msg_idx  <= count_q;
      end

      if ((state_q == ST_PRESENT) && bus.msg_ready) begin
        count_q           <= count_q + 4'd1;
        bus.sha_bram_addr <= bus.sha_bram_addr + STRIDE;
      end
    end
  end

`ifdef SHA_FETCH_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog and sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      wd_q          <= '0;
      bus.fetch_err <= 1'b0;
    end else begin
      if (state_next != state_q) begin
        wd_q <= '0;
      end else if ((state_q == ST_REQ) || (state_q == ST_RELEASE)) begin
        wd_q <= wd_q + 8'd1;
      end

      if ((state_q == ST_IDLE) && bus.fetch_start) begin
        bus.fetch_err <= 1'b0;
      end else if ((state_next == ST_ABORT) && (state_q != ST_ABORT)) begin
        bus.fetch_err <= 1'b1;
      end
    end
  end
`else
  assign bus.fetch_err = 1'b0;
`endif

endmodule : sha_block_fetch

// File: tb/tb_sha_block_fetch.sv
// -----------------------------------------------------------------------------
// tb_sha_block_fetch
//
// Directed bench for sha_block_fetch. A BRAM responder answers each read with
// data = addr ^ 0xA5A50000 after a programmable latency. Expected addresses
// and words are queued when a fetch is started and popped by monitors when
// the DUT issues a read or completes a message handshake.
// With SHA_FETCH_TIMEOUT_EN defined, the watchdog abort scenario is added.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sha_block_fetch;

  localparam int          WORDS    = 16;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] word;
  } exp_word_t;

  logic clk;
  logic rst_n;

  sha_block_fetch_if bus();

  sha_block_fetch #(
    .WORDS          (WORDS),
    .ADDR_STRIDE    (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .axi_clk (clk),
    .axi_rst (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int done_count = 0;

  logic [31:0] exp_addr_q[$];
  exp_word_t   exp_word_q[$];

  // BRAM responder controls
  int bram_lat  = 1;
  bit bram_hang = 1'b0;
  int lat_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic [31:0] base);
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] a;
      a = base + 32'(i) * 32'd4;
      exp_addr_q.push_back(a);
      exp_word_q.push_back('{idx: 4'(i), word: a ^ DATA_KEY});
    end
  endtask

  // ---------------------------------------------------------------------------
  // BRAM interface model: complete rises after the latency and holds until
  // sha_start_read drops.
  // ---------------------------------------------------------------------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bram_complete      <= 1'b0;
      bus.sha_bram_read_data <= '0;
      lat_cnt                <= 0;
    end else if (!bus.sha_start_read) begin
      bus.bram_complete <= 1'b0;
      lat_cnt           <= 0;
    end else if (!bus.bram_complete && !bram_hang) begin
      if (lat_cnt >= bram_lat) begin
        bus.bram_complete      <= 1'b1;
        bus.sha_bram_read_data <= bus.sha_bram_addr ^ DATA_KEY;
        lat_cnt                <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic        prev_sr;
  logic        prev_stall;
  logic [31:0] prev_word;
  logic [3:0]  prev_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sr    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.sha_start_read && !prev_sr) begin
        if (exp_addr_q.size() == 0) begin
          check("addr_unexpected_read", bus.sha_bram_addr, 32'hFFFF_FFFF ^ bus.sha_bram_addr);
        end else begin
          check("bram_addr", bus.sha_bram_addr, exp_addr_q.pop_front());
        end
      end
      prev_sr = bus.sha_start_read;

      if (prev_stall) begin
        check("stall_valid_held", {31'd0, bus.msg_valid}, 32'd1);
        check("stall_word_stable", bus.msg_word, prev_word);
        check("stall_idx_stable", {28'd0, bus.msg_idx}, {28'd0, prev_idx});
      end
      prev_stall = bus.msg_valid && !bus.msg_ready;
      prev_word  = bus.msg_word;
      prev_idx   = bus.msg_idx;

      if (bus.msg_valid && bus.msg_ready) begin
        if (exp_word_q.size() == 0) begin
          check("word_unexpected", {28'd0, bus.msg_idx}, 32'hFFFF_FFFF);
        end else begin
          exp_word_t e;
          e = exp_word_q.pop_front();
          check("msg_word", bus.msg_word, e.word);
          check("msg_idx", {28'd0, bus.msg_idx}, {28'd0, e.idx});
        end
      end

      if (bus.fetch_done) done_count++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic start_fetch(input logic [31:0] base);
    @(posedge clk); #1;
    bus.fetch_base_addr = base;
    bus.fetch_start     = 1'b1;
    @(posedge clk); #1;
    bus.fetch_start     = 1'b0;
    bus.fetch_base_addr = 32'h0BAD_0000;
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    check("start_read_1cyc", {31'd0, bus.sha_start_read}, 32'd1);
    check("start_addr", bus.sha_bram_addr, base);
    check("start_err_clear", {31'd0, bus.fetch_err}, 32'd0);
  endtask

  task automatic run_fetch(input logic [31:0] base, input bit rand_ready, input bit inject);
    int  cyc;
    int  done_base;
    bit  done_seen;
    bit  inj3;
    bit  inj9;
    done_base = done_count;
    done_seen = 1'b0;
    inj3      = 1'b0;
    inj9      = 1'b0;
    cyc       = 0;
    push_expect(base);
    bus.msg_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start_fetch(base);
    while (!done_seen && cyc < 3000) begin
      bus.fetch_start = 1'b0;
      bus.msg_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && bus.msg_valid && !inj3 && bus.msg_idx == 4'd3) begin
        inj3 = 1'b1;
        bus.fetch_start     = 1'b1;
        bus.fetch_base_addr = 32'hDEAD_0000;
      end else if (inject && bus.msg_valid && !inj9 && bus.msg_idx == 4'd9) begin
        inj9 = 1'b1;
        bus.fetch_start     = 1'b1;
        bus.fetch_base_addr = 32'hDEAD_1000;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.fetch_done) done_seen = 1'b1;
    end
    bus.fetch_start = 1'b0;
    bus.msg_ready   = 1'b1;
    check("done_within_budget", {31'd0, done_seen}, 32'd1);
    @(posedge clk); #1;
    check("busy_low_after_done", {31'd0, bus.busy}, 32'd0);
    check("done_one_cycle", {31'd0, bus.fetch_done}, 32'd0);
    check("done_pulse_count", 32'(done_count - done_base), 32'd1);
    check("words_drained", 32'(exp_word_q.size()), 32'd0);
    check("addrs_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n               = 1'b0;
    bus.fetch_start     = 1'b0;
    bus.fetch_base_addr = '0;
    bus.msg_ready       = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.fetch_done}, 32'd0);
    check("rst_err", {31'd0, bus.fetch_err}, 32'd0);
    check("rst_start_read", {31'd0, bus.sha_start_read}, 32'd0);
    check("rst_valid", {31'd0, bus.msg_valid}, 32'd0);
    check("rst_addr", bus.sha_bram_addr, 32'd0);
    check("rst_word", bus.msg_word, 32'd0);
    check("rst_idx", {28'd0, bus.msg_idx}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Basic block, ready held high; last word 0xA5A5013C
    bram_lat = 1;
    run_fetch(32'h0000_0100, 1'b0, 1'b0);
    check("last_word_base100", bus.msg_word, 32'hA5A5_013C);
    check("last_idx_base100", {28'd0, bus.msg_idx}, 32'd15);

    // Same block, pseudo-random back-pressure and a slower BRAM
    bram_lat = 3;
    run_fetch(32'h0000_0100, 1'b1, 1'b0);

    // Address wrap past 0xFFFFFFFC, zero-latency BRAM
    bram_lat = 0;
    run_fetch(32'hFFFF_FFF8, 1'b0, 1'b0);
    check("last_word_wrap", bus.msg_word, 32'h0000_0034 ^ DATA_KEY);

    // fetch_start pulses at words 3 and 9 must be ignored
    bram_lat = 2;
    run_fetch(32'h0000_4000, 1'b1, 1'b1);

    // Reset while requesting word 7
    begin
      int cyc;
      cyc = 0;
      bram_lat = 1;
      push_expect(32'h0000_2000);
      start_fetch(32'h0000_2000);
      bus.msg_ready = 1'b1;
      while (!(bus.sha_start_read && bus.sha_bram_addr == 32'h0000_201C) && cyc < 500) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("reach_word7_req", {31'd0, bus.sha_start_read}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_start_read", {31'd0, bus.sha_start_read}, 32'd0);
      check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("async_rst_valid", {31'd0, bus.msg_valid}, 32'd0);
      exp_addr_q.delete();
      exp_word_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_fetch(32'h0000_3000, 1'b0, 1'b0);
    end

`ifdef SHA_FETCH_TIMEOUT_EN
    // BRAM never completes: watchdog abort after 64 cycles in REQ
    begin
      int hi_cycles;
      int done_base;
      done_base = done_count;
      bram_hang = 1'b1;
      exp_addr_q.push_back(32'h0000_0400);
      start_fetch(32'h0000_0400);
      hi_cycles = 1;
      while (bus.sha_start_read && hi_cycles < 300) begin
        @(posedge clk); #1;
        if (bus.sha_start_read) hi_cycles++;
      end
      check("timeout_req_cycles", 32'(hi_cycles), 32'd64);
      check("timeout_err_set", {31'd0, bus.fetch_err}, 32'd1);
      check("timeout_start_read_low", {31'd0, bus.sha_start_read}, 32'd0);
      check("timeout_valid_low", {31'd0, bus.msg_valid}, 32'd0);
      @(posedge clk); #1;
      check("timeout_back_idle", {31'd0, bus.busy}, 32'd0);
      check("timeout_err_sticky", {31'd0, bus.fetch_err}, 32'd1);
      check("timeout_no_done", 32'(done_count - done_base), 32'd0);
      bram_hang = 1'b0;
      run_fetch(32'h0000_0500, 1'b0, 1'b0);
    end
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no completion, required finish before 2 ms");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule : tb_sha_block_fetch
